// File: rtl/instr_decode_pkg.sv
// Shared definitions for the RV32 decode stage: one-hot operation indices,
// opcode/funct7 constants, immediate format enum and pipeline state enum.
// The RV32M_EN macro, used in instr_decode.sv, enables MUL/DIV decode.
package instr_decode_pkg;

  localparam int NUM_OPS = 47;

  // One-hot bit positions of the ALU-facing operation vector
  localparam logic [5:0] IDX_LUI    = 6'd0;
  localparam logic [5:0] IDX_AUIPC  = 6'd1;
  localparam logic [5:0] IDX_JAL    = 6'd2;
  localparam logic [5:0] IDX_JALR   = 6'd3;
  localparam logic [5:0] IDX_BEQ    = 6'd4;
  localparam logic [5:0] IDX_BNE    = 6'd5;
  localparam logic [5:0] IDX_BLT    = 6'd6;
  localparam logic [5:0] IDX_BGE    = 6'd7;
  localparam logic [5:0] IDX_BLTU   = 6'd8;
  localparam logic [5:0] IDX_BGEU   = 6'd9;
  localparam logic [5:0] IDX_LB     = 6'd10;
  localparam logic [5:0] IDX_LH     = 6'd11;
  localparam logic [5:0] IDX_LW     = 6'd12;
  localparam logic [5:0] IDX_LBU    = 6'd13;
  localparam logic [5:0] IDX_LHU    = 6'd14;
  localparam logic [5:0] IDX_SB     = 6'd15;
  localparam logic [5:0] IDX_SH     = 6'd16;
  localparam logic [5:0] IDX_SW     = 6'd17;
  localparam logic [5:0] IDX_ADDI   = 6'd18;
  localparam logic [5:0] IDX_SLTI   = 6'd19;
  localparam logic [5:0] IDX_SLTIU  = 6'd20;
  localparam logic [5:0] IDX_XORI   = 6'd21;
  localparam logic [5:0] IDX_ORI    = 6'd22;
  localparam logic [5:0] IDX_ANDI   = 6'd23;
  localparam logic [5:0] IDX_SLLI   = 6'd24;
  localparam logic [5:0] IDX_SRLI   = 6'd25;
  localparam logic [5:0] IDX_SRAI   = 6'd26;
  localparam logic [5:0] IDX_ADD    = 6'd27;
  localparam logic [5:0] IDX_SUB    = 6'd28;
  localparam logic [5:0] IDX_SLL    = 6'd29;
  localparam logic [5:0] IDX_SLT    = 6'd30;
  localparam logic [5:0] IDX_SLTU   = 6'd31;
  localparam logic [5:0] IDX_XOR    = 6'd32;
  localparam logic [5:0] IDX_SRL    = 6'd33;
  localparam logic [5:0] IDX_SRA    = 6'd34;
  localparam logic [5:0] IDX_OR     = 6'd35;
  localparam logic [5:0] IDX_AND    = 6'd36;
  localparam logic [5:0] IDX_FENCE  = 6'd37;
  localparam logic [5:0] IDX_ECALL  = 6'd38;
  localparam logic [5:0] IDX_MUL    = 6'd39;
  localparam logic [5:0] IDX_MULH   = 6'd40;
  localparam logic [5:0] IDX_MULHSU = 6'd41;
  localparam logic [5:0] IDX_MULHU  = 6'd42;
  localparam logic [5:0] IDX_DIV    = 6'd43;
  localparam logic [5:0] IDX_DIVU   = 6'd44;
  localparam logic [5:0] IDX_REM    = 6'd45;
  localparam logic [5:0] IDX_REMU   = 6'd46;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // funct7 values that select between operation variants
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Expand an operation index into the one-hot operation vector
  function automatic logic [NUM_OPS-1:0] op_onehot(input logic [5:0] idx);
    logic [NUM_OPS-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      v[k] = (idx == 6'(k));
    end
    return v;
  endfunction

endpackage

// File: rtl/instr_decode_imm_gen.sv
// Immediate generator: sign-extended I/S/B/U/J immediate chosen by format.
// R-type yields zero. Only instr[31:7] carries immediate bits.
module imm_gen
  import instr_decode_pkg::*;
(
  input  logic [31:7] i_instr,
  input  fmt_t        i_format,
  output logic [31:0] o_imm
);

  // Reassemble the immediate field for the selected format
  always_comb begin
    o_imm = '0;
    case (i_format)
      FMT_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      FMT_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      FMT_U: o_imm = {i_instr[31:12], 12'b0};
      FMT_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/instr_decode.sv
// RV32I(+M) decode stage: one registered pipeline slot between fetch and ALU.
// Build option: define RV32M_EN to decode the MUL/DIV/REM group (bits 39-46);
// without it those encodings are reported as illegal.
//
// Handshake: a beat moves on a side when valid && ready are both high in the
// same cycle. in_ready = !out_valid || out_ready, so a full slot accepts a new
// instruction in the same cycle its bundle leaves. The slot state is directly
// visible as out_valid (EMPTY = 0, FULL = 1).
module instr_decode
  import instr_decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  input  logic [31:0]        in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OPS-1:0] instructions,
  output logic [4:0]         rs1_addr,
  output logic [4:0]         rs2_addr,
  output logic [4:0]         rd_addr,
  output logic [31:0]        imm,
  output logic [31:0]        out_pc,
  output logic               illegal,
  input  logic               flush
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_load;

  logic [6:0]         w_opcode;
  logic [2:0]         w_funct3;
  logic [6:0]         w_funct7;
  logic               w_hit;
  logic [5:0]         w_idx;
  fmt_t               w_fmt;
  logic [NUM_OPS-1:0] w_onehot;
  logic [31:0]        w_imm_raw;
  logic [31:0]        w_imm;

  logic [NUM_OPS-1:0] r_instructions;
  logic [4:0]         r_rs1;
  logic [4:0]         r_rs2;
  logic [4:0]         r_rd;
  logic [31:0]        r_imm;
  logic [31:0]        r_pc;
  logic               r_illegal;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];

  // Slot state register; reset wins over flush and both handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake and next-state; flush empties the slot and drops any input beat
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = (r_state == ST_EMPTY) || out_ready;
    w_in_xfer   = in_valid && in_ready;
    w_out_xfer  = (r_state == ST_FULL) && out_ready;
    w_load      = w_in_xfer && !flush;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else if (w_in_xfer) begin
      w_state_nxt = ST_FULL;
    end else if (w_out_xfer) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // Operation decode: opcode, funct3 and funct7 must all match a known encoding
  always_comb begin
    w_hit = 1'b0;
    w_idx = IDX_LUI;
    w_fmt = FMT_R;
    if (instr[1:0] == 2'b11) begin
      case (w_opcode)
        OPC_LUI: begin
          w_hit = 1'b1; w_idx = IDX_LUI; w_fmt = FMT_U;
        end
        OPC_AUIPC: begin
          w_hit = 1'b1; w_idx = IDX_AUIPC; w_fmt = FMT_U;
        end
        OPC_JAL: begin
          w_hit = 1'b1; w_idx = IDX_JAL; w_fmt = FMT_J;
        end
        OPC_JALR: begin
          w_fmt = FMT_I;
          if (w_funct3 == 3'b000) begin
            w_hit = 1'b1; w_idx = IDX_JALR;
          end
        end
        OPC_BRANCH: begin
          w_fmt = FMT_B;
          w_hit = 1'b1;
          case (w_funct3)
            3'b000:  w_idx = IDX_BEQ;
            3'b001:  w_idx = IDX_BNE;
            3'b100:  w_idx = IDX_BLT;
            3'b101:  w_idx = IDX_BGE;
            3'b110:  w_idx = IDX_BLTU;
            3'b111:  w_idx = IDX_BGEU;
            default: w_hit = 1'b0;
          endcase
        end
        OPC_LOAD: begin
          w_fmt = FMT_I;
          w_hit = 1'b1;
          case (w_funct3)
            3'b000:  w_idx = IDX_LB;
            3'b001:  w_idx = IDX_LH;
            3'b010:  w_idx = IDX_LW;
            3'b100:  w_idx = IDX_LBU;
            3'b101:  w_idx = IDX_LHU;
            default: w_hit = 1'b0;
          endcase
        end
        OPC_STORE: begin
          w_fmt = FMT_S;
          w_hit = 1'b1;
          case (w_funct3)
            3'b000:  w_idx = IDX_SB;
            3'b001:  w_idx = IDX_SH;
            3'b010:  w_idx = IDX_SW;
            default: w_hit = 1'b0;
          endcase
        end
        OPC_OP_IMM: begin
          w_fmt = FMT_I;
          w_hit = 1'b1;
          case (w_funct3)
            3'b000: w_idx = IDX_ADDI;
            3'b010: w_idx = IDX_SLTI;
            3'b011: w_idx = IDX_SLTIU;
            3'b100: w_idx = IDX_XORI;
            3'b110: w_idx = IDX_ORI;
            3'b111: w_idx = IDX_ANDI;
            // Shift-immediates reuse the upper imm bits as funct7
            3'b001: begin
              w_idx = IDX_SLLI;
              w_hit = (w_funct7 == F7_BASE);
            end
            default: begin
              if (w_funct7 == F7_BASE) begin
                w_idx = IDX_SRLI;
              end else if (w_funct7 == F7_ALT) begin
                w_idx = IDX_SRAI;
              end else begin
                w_hit = 1'b0;
              end
            end
          endcase
        end
        OPC_OP: begin
          w_fmt = FMT_R;
          if (w_funct7 == F7_BASE) begin
            w_hit = 1'b1;
            case (w_funct3)
              3'b000:  w_idx = IDX_ADD;
              3'b001:  w_idx = IDX_SLL;
              3'b010:  w_idx = IDX_SLT;
              3'b011:  w_idx = IDX_SLTU;
              3'b100:  w_idx = IDX_XOR;
              3'b101:  w_idx = IDX_SRL;
              3'b110:  w_idx = IDX_OR;
              default: w_idx = IDX_AND;
            endcase
          end else if (w_funct7 == F7_ALT) begin
            if (w_funct3 == 3'b000) begin
              w_hit = 1'b1; w_idx = IDX_SUB;
            end else if (w_funct3 == 3'b101) begin
              w_hit = 1'b1; w_idx = IDX_SRA;
            end
`ifdef RV32M_EN
          end else if (w_funct7 == F7_MULDIV) begin
            // MUL..REMU are laid out in funct3 order
            w_hit = 1'b1;
            w_idx = IDX_MUL + {3'b000, w_funct3};
`endif
          end
        end
        OPC_MISC_MEM: begin
          w_fmt = FMT_I;
          if (w_funct3 == 3'b000) begin
            w_hit = 1'b1; w_idx = IDX_FENCE;
          end
        end
        OPC_SYSTEM: begin
          // Only ECALL (imm=0) and EBREAK (imm=1) with rd=rs1=funct3=0
          w_fmt = FMT_I;
          if ((instr[31:21] == 11'd0) && (instr[19:7] == 13'd0)) begin
            w_hit = 1'b1; w_idx = IDX_ECALL;
          end
        end
        default: begin
          w_hit = 1'b0;
        end
      endcase
    end
  end

  // Without RV32M_EN no decode path produces indices 39-46, so those bits stay 0
  assign w_onehot = w_hit ? op_onehot(w_idx) : '0;

  imm_gen u_imm_gen (
    .i_instr  (instr[31:7]),
    .i_format (w_fmt),
    .o_imm    (w_imm_raw)
  );

  assign w_imm = w_hit ? w_imm_raw : 32'h0;

  // Output bundle; loads only on an accepted (non-flushed) input beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instructions <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_rd           <= '0;
      r_imm          <= '0;
      r_pc           <= RESET_PC_TAG;
      r_illegal      <= 1'b0;
    end else if (w_load) begin
      r_instructions <= w_onehot;
      r_rs1          <= instr[19:15];
      r_rs2          <= instr[24:20];
      r_rd           <= instr[11:7];
      r_imm          <= w_imm;
      r_pc           <= in_pc;
      r_illegal      <= !w_hit;
    end
  end

  assign out_valid    = (r_state == ST_FULL);
  assign instructions = r_instructions;
  assign rs1_addr     = r_rs1;
  assign rs2_addr     = r_rs2;
  assign rd_addr      = r_rd;
  assign imm          = r_imm;
  assign out_pc       = r_pc;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: directed steps followed by randomized traffic, all
// checked against a mask/match table model of the RV32 encodings.
module tb_instr_decode;

  localparam logic [31:0] TAG = 32'hDEAD_0000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [46:0] instructions;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] imm;
  logic [31:0] out_pc;
  logic        illegal;
  logic        flush;

  int checks = 0;
  int errors = 0;

  // Encoding table: an instruction word w decodes to t_idx[k] when (w & mask)==match
  logic [31:0] t_mask[$];
  logic [31:0] t_match[$];
  int          t_idx[$];
  int          t_fmt[$];   // 0=R 1=I 2=S 3=B 4=U 5=J

  // Model of the output slot
  logic        m_valid;
  logic [46:0] m_oh;
  logic [31:0] m_imm;
  logic [31:0] m_pc;
  logic [4:0]  m_rd;
  logic [4:0]  m_rs1;
  logic [4:0]  m_rs2;
  logic        m_ill;

  instr_decode #(.RESET_PC_TAG(TAG)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .instructions (instructions),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rd_addr      (rd_addr),
    .imm          (imm),
    .out_pc       (out_pc),
    .illegal      (illegal),
    .flush        (flush)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tadd(input logic [31:0] mask, input logic [31:0] match, input int idx,
                      input int fmt);
    t_mask.push_back(mask);
    t_match.push_back(match);
    t_idx.push_back(idx);
    t_fmt.push_back(fmt);
  endtask

  task automatic build_table();
    int f3_br[6] = '{0, 1, 4, 5, 6, 7};
    int f3_ld[5] = '{0, 1, 2, 4, 5};
    int f3_oi[6] = '{0, 2, 3, 4, 6, 7};
    int f3_op[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int ix_op[8] = '{27, 29, 30, 31, 32, 33, 35, 36};
    tadd(32'h0000007F, 32'h00000037, 0, 4);
    tadd(32'h0000007F, 32'h00000017, 1, 4);
    tadd(32'h0000007F, 32'h0000006F, 2, 5);
    tadd(32'h0000707F, 32'h00000067, 3, 1);
    for (int i = 0; i < 6; i++) tadd(32'h0000707F, 32'h63 | (f3_br[i] << 12), 4 + i, 3);
    for (int i = 0; i < 5; i++) tadd(32'h0000707F, 32'h03 | (f3_ld[i] << 12), 10 + i, 1);
    for (int i = 0; i < 3; i++) tadd(32'h0000707F, 32'h23 | (i << 12), 15 + i, 2);
    for (int i = 0; i < 6; i++) tadd(32'h0000707F, 32'h13 | (f3_oi[i] << 12), 18 + i, 1);
    tadd(32'hFE00707F, 32'h00001013, 24, 1);
    tadd(32'hFE00707F, 32'h00005013, 25, 1);
    tadd(32'hFE00707F, 32'h40005013, 26, 1);
    for (int i = 0; i < 8; i++) tadd(32'hFE00707F, 32'h33 | (f3_op[i] << 12), ix_op[i], 0);
    tadd(32'hFE00707F, 32'h40000033, 28, 0);
    tadd(32'hFE00707F, 32'h40005033, 34, 0);
    tadd(32'h0000707F, 32'h0000000F, 37, 1);
    tadd(32'hFFFFFFFF, 32'h00000073, 38, 1);
    tadd(32'hFFFFFFFF, 32'h00100073, 38, 1);
`ifdef RV32M_EN
    for (int i = 0; i < 8; i++) tadd(32'hFE00707F, 32'h02000033 | (i << 12), 39 + i, 0);
`endif
  endtask

  // Immediate from the field layout of each format, using arithmetic shifts
  function automatic logic [31:0] ref_imm(input logic [31:0] w, input int fmt);
    logic [31:0] sx;
    case (fmt)
      1: begin
        sx = $signed(w) >>> 20;
        return sx;
      end
      2: begin
        sx = $signed(w) >>> 25;
        return (sx << 5) | ((w >> 7) & 32'h1F);
      end
      3: begin
        sx = $signed(w) >>> 31;
        return (sx << 12) | (((w >> 7) & 32'h1) << 11) | (((w >> 25) & 32'h3F) << 5)
               | (((w >> 8) & 32'hF) << 1);
      end
      4: return w & 32'hFFFFF000;
      5: begin
        sx = $signed(w) >>> 31;
        return (sx << 20) | (w & 32'h000FF000) | (((w >> 20) & 32'h1) << 11)
               | (((w >> 21) & 32'h3FF) << 1);
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic ref_decode(input logic [31:0] w, output logic [46:0] oh,
                            output logic [31:0] im, output logic ill);
    int hit;
    int fmt;
    hit = -1;
    fmt = 0;
    foreach (t_mask[k]) begin
      if (hit < 0 && (w & t_mask[k]) == t_match[k]) begin
        hit = t_idx[k];
        fmt = t_fmt[k];
      end
    end
    if (hit < 0) begin
      oh  = '0;
      im  = '0;
      ill = 1'b1;
    end else begin
      oh  = 47'(1) << hit;
      im  = ref_imm(w, fmt);
      ill = 1'b0;
    end
  endtask

  // One clock cycle of stimulus, model update and full output comparison
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic rs);
    logic exp_rdy;
    in_valid  = v;
    instr     = w;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    #1;
    exp_rdy = !m_valid || ordy;
    if (!rs) chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (rs) begin
      m_valid = 1'b0; m_oh = '0; m_imm = '0; m_pc = TAG;
      m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_ill = 1'b0;
    end else if (fl) begin
      m_valid = 1'b0;
    end else if (v && exp_rdy) begin
      ref_decode(w, m_oh, m_imm, m_ill);
      m_valid = 1'b1;
      m_pc  = pc;
      m_rd  = w[11:7];
      m_rs1 = w[19:15];
      m_rs2 = w[24:20];
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("instructions", 64'(instructions), 64'(m_oh));
    chk("imm", 64'(imm), 64'(m_imm));
    chk("illegal", 64'(illegal), 64'(m_ill));
    chk("out_pc", 64'(out_pc), 64'(m_pc));
    chk("rd_addr", 64'(rd_addr), 64'(m_rd));
    chk("rs1_addr", 64'(rs1_addr), 64'(m_rs1));
    chk("rs2_addr", 64'(rs2_addr), 64'(m_rs2));
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    case ($urandom_range(0, 9))
      0: return $urandom();
      1: return 32'h02000033 | ($urandom() & 32'h01FFFF80) | (32'($urandom_range(0, 7)) << 12);
      default: begin
        k = $urandom_range(0, t_mask.size() - 1);
        return ($urandom() & ~t_mask[k]) | t_match[k];
      end
    endcase
  endfunction

  logic [31:0] dir_words[10] = '{32'h00100073, 32'h00000073, 32'h0FF0000F, 32'h40515093,
                                 32'h40511093, 32'h00510091, 32'hFE000EE3, 32'hFFDFF0EF,
                                 32'h800002B7, 32'h00209073};

  initial begin
    build_table();
    m_valid = 1'b0; m_oh = '0; m_imm = '0; m_pc = TAG;
    m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_ill = 1'b0;

    // Reset, then one idle cycle: slot empty and ready
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("ready_after_reset", 64'(in_ready), 64'd1);

    // ADDI x1,x2,5
    step(1'b1, 32'h00510093, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
    chk("addi_onehot", 64'(instructions), 64'(1) << 18);
    chk("addi_rd", 64'(rd_addr), 64'd1);
    chk("addi_rs1", 64'(rs1_addr), 64'd2);
    chk("addi_imm", 64'(imm), 64'h5);
    chk("addi_illegal", 64'(illegal), 64'd0);

    // MUL x3,x1,x2
    step(1'b1, 32'h022081B3, 32'h0000_0104, 1'b1, 1'b0, 1'b0);
`ifdef RV32M_EN
    chk("mul_onehot", 64'(instructions), 64'(1) << 39);
    chk("mul_rd", 64'(rd_addr), 64'd3);
    chk("mul_rs1", 64'(rs1_addr), 64'd1);
    chk("mul_rs2", 64'(rs2_addr), 64'd2);
`else
    chk("mul_illegal", 64'(illegal), 64'd1);
    chk("mul_onehot_zero", 64'(instructions), 64'd0);
`endif

    // Drain, then back-pressure for three cycles with new input pending
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h00832283, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h00742623, 32'h0000_0300 + 32'(i), 1'b0, 1'b0, 1'b0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_pc_held", 64'(out_pc), 64'h200);
    end
    step(1'b1, 32'h00742623, 32'h0000_0304, 1'b1, 1'b0, 1'b0);
    chk("bp_new_pc", 64'(out_pc), 64'h304);
    chk("bp_sw_imm", 64'(imm), 64'd12);

    // All-ones word is illegal
    step(1'b1, 32'hFFFFFFFF, 32'h0000_0400, 1'b1, 1'b0, 1'b0);
    chk("ones_illegal", 64'(illegal), 64'd1);
    chk("ones_onehot", 64'(instructions), 64'd0);
    chk("ones_imm", 64'(imm), 64'd0);
    chk("ones_valid", 64'(out_valid), 64'd1);

    // Flush with a would-be input transfer: slot empties, input dropped
    step(1'b1, 32'h00510093, 32'h0000_0500, 1'b1, 1'b1, 1'b0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_pc_kept", 64'(out_pc), 64'h400);

    // Reset while full and back-pressured
    step(1'b1, 32'h00510093, 32'h0000_0600, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h00510093, 32'h0000_0604, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00510093, 32'h0000_0608, 1'b0, 1'b1, 1'b1);
    chk("rst_full_valid", 64'(out_valid), 64'd0);
    chk("rst_full_pc", 64'(out_pc), 64'(TAG));
    chk("rst_full_onehot", 64'(instructions), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_full_ready", 64'(in_ready), 64'd1);

    // Directed encodings: system, fence, shifts, low-bit check, B/J/U/CSR
    foreach (dir_words[i]) begin
      step(1'b1, dir_words[i], 32'h0000_0700 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have one parameter: RESET_PC_TAG, default 32'h0, the value loaded into out_pc at reset.
REQ-002 SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  instr/in_pc present.
- in_ready  out  1  stage can accept.
- instr  in  32  RV32 instruction word.
- in_pc  in  32  PC of instr.
- out_valid  out  1  decoded bundle present.
- out_ready  in  1  consumer (ALU stage) accepts.
- instructions  out  47  one-hot decoded operation, ALU-facing.
- rs1_addr, rs2_addr, rd_addr  out  5 each  register indices.
- imm  out  32  sign-extended immediate.
- out_pc  out  32  registered in_pc.
- illegal  out  1  instr not decodable.
- flush  in  1  discard the held bundle.

Function
REQ-003 SHALL be a single registered pipeline stage with 1-cycle latency: an accepted instr appears on the outputs on the next cycle with out_valid=1.
REQ-004 Input handshake: a transfer occurs when in_valid && in_ready. in_ready = !out_valid || out_ready, a combinational path that allows one transfer per cycle.
REQ-005 Output handshake: a transfer occurs when out_valid && out_ready. While out_valid=1 && out_ready=0, all outputs SHALL be held stable.
REQ-006 State: EMPTY (out_valid=0) or FULL (out_valid=1).
- EMPTY->FULL on input transfer.
- FULL->FULL on simultaneous output and input transfer.
- FULL->EMPTY on output transfer with no input transfer.
REQ-007 flush=1 SHALL clear out_valid on the next cycle and take priority over a simultaneous input transfer, which is dropped; in_ready is still computed per REQ-004.
REQ-008 instructions SHALL be exactly one-hot for a legal instr and all-zero when illegal=1.
- Bit map: bits 0-36 RV32I base (LUI, AUIPC, JAL, JALR, 6 branches, 5 loads, 3 stores, 9 OP-IMM, 10 OP).
- Bit 37 FENCE, bit 38 ECALL/EBREAK.
- Bits 39-46 RV32M (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-009 Decode SHALL check opcode, funct3 and funct7. Any mismatch, including a shift-immediate with a nonzero illegal funct7 or instr[1:0]!=2'b11, SHALL set illegal=1.
REQ-010 imm SHALL be the sign-extended I/S/B/U/J immediate selected by format. B and J immediates have bit0=0. imm=0 for R-type and illegal.
REQ-011 Register fields SHALL always be extracted from fixed positions, regardless of format: rd=instr[11:7], rs1=instr[19:15], rs2=instr[24:20].
REQ-012 Output registers SHALL update only on an input transfer; the data path is not cleared on an output transfer.

Reset
REQ-013 On rst=1 at a clock edge the following SHALL load:
- out_valid=0, illegal=0;
- instructions=0, imm=0;
- rs1_addr=0, rs2_addr=0, rd_addr=0;
- out_pc=RESET_PC_TAG.
REQ-014 rst SHALL override flush and any handshake in the same cycle. A bundle held mid-backpressure is lost.
REQ-015 in_ready SHALL be 1 in the cycle after reset.

Configuration
REQ-016 Macro RV32M_EN:
- Defined: bits 39-46 decode funct7=7'b0000001 OP encodings.
- Undefined: bits 39-46 SHALL be constant 0, and those encodings set illegal=1.

Structure
REQ-017 Package instr_decode_pkg SHALL hold:
- the 47 bit-index localparams (IDX_LUI ... IDX_REMU);
- the opcode constants;
- the format enum (R, I, S, B, U, J);
- NUM_OPS=47.
REQ-018 Sub-module imm_gen SHALL be used: combinational, inputs instr and format, output 32-bit imm.

Verification
REQ-019 instr=32'h00510093 (ADDI x1,x2,5):
- next cycle out_valid=1 and instructions bit IDX_ADDI set only;
- rd=1, rs1=2, imm=32'h5, illegal=0.
REQ-020 instr=32'h022081B3 (MUL x3,x1,x2):
- with RV32M_EN: bit IDX_MUL set, rd=3, rs1=1, rs2=2;
- without RV32M_EN: illegal=1, instructions=0.
REQ-021 Back-pressure: out_ready=0 for 3 cycles after a transfer:
- in_ready=0 throughout;
- outputs constant;
- out_ready=1 completes the transfer, and a new instr is accepted in the same cycle.
REQ-022 instr=32'hFFFFFFFF -> illegal=1, instructions=0, imm=0, out_valid=1.
REQ-023 Overlapping controls:
- flush asserted with in_valid=1 -> out_valid=0 next cycle, input dropped;
- rst asserted while FULL -> all outputs at reset values next cycle;
- in_ready=1 the cycle after reset.
